// File: rtl/alu_seq.sv
// Handshaked integer ALU: single-cycle base OP/OP-IMM operations and an
// iterative, one-bit-per-cycle shared multiply/divide datapath.
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op,
    input  logic            op_imm,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] t,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_TOP = {SHW{1'b1}};
    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_FIN
    } state_t;

    state_t          state_q;
    logic [SHW-1:0]  cnt_q;
    logic            out_valid_q;
    logic [XLEN-1:0] t_q;
    logic            illegal_q;

    // Shared datapath: acc holds {hi, lo} for multiply and {rem, quo} for divide;
    // opd holds the multiplicand magnitude or the divisor magnitude.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [2:0]        f3_q, f3_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic            f7_zero, f7_alt, f7_m;
    logic            dec_ill, is_m, is_mul, is_div;
    logic            a_sgn, b_sgn, sa, sb;
    logic            div_zero, div_ovf, div_short;
    logic            accept;
    logic [XLEN-1:0] sc_res, imm_res, seq_res;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [2*XLEN-1:0] prod;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [XLEN-1:0] base_op(
        input logic [2:0]      f3,
        input logic            sub,
        input logic            arith,
        input logic [XLEN-1:0] x,
        input logic [XLEN-1:0] y
    );
        logic [SHW-1:0]         sh;
        logic signed [XLEN-1:0] xs;
        logic signed [XLEN-1:0] ys;
        logic signed [XLEN-1:0] sra;
        sh  = y[SHW-1:0];
        xs  = x;
        ys  = y;
        sra = xs >>> sh;
        case (f3)
            3'b000:  base_op = sub ? (x - y) : (x + y);
            3'b001:  base_op = x << sh;
            3'b010:  base_op = {{(XLEN-1){1'b0}}, (xs < ys)};
            3'b011:  base_op = {{(XLEN-1){1'b0}}, (x < y)};
            3'b100:  base_op = x ^ y;
            3'b101:  base_op = arith ? sra : (x >> sh);
            3'b110:  base_op = x | y;
            default: base_op = x & y;
        endcase
    endfunction

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign t         = t_q;
    assign illegal   = illegal_q;

    always_comb begin
        f7_zero = (funct7 == 7'b0000000);
        f7_alt  = (funct7 == 7'b0100000);
        f7_m    = (funct7 == 7'b0000001);
        dec_ill = !(op ^ op_imm);
        if (op && !op_imm) begin
            if (!(f7_zero || f7_alt || f7_m)) dec_ill = 1'b1;
            if (f7_alt && (funct3 != 3'b000) && (funct3 != 3'b101)) dec_ill = 1'b1;
        end
        // For OP-IMM only the shifts carry funct7; elsewhere those bits are immediate.
        if (op_imm && !op && ((funct3 == 3'b001) || (funct3 == 3'b101))) begin
            if (!(f7_zero || f7_alt)) dec_ill = 1'b1;
            if ((funct3 == 3'b001) && f7_alt) dec_ill = 1'b1;
        end

        is_m   = op && !op_imm && f7_m;
        is_mul = is_m && !funct3[2];
        is_div = is_m && funct3[2];

        a_sgn = is_div ? !funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
        b_sgn = is_div ? !funct3[0] : (funct3 == 3'b001);
        sa    = a_sgn && a[XLEN-1];
        sb    = b_sgn && b[XLEN-1];

        div_zero  = (b == '0);
        div_ovf   = !funct3[0] && (a == MOST_NEG) && (b == '1);
        div_short = is_div && (div_zero || div_ovf);
        if (div_zero) sc_res = funct3[1] ? a : '1;
        else          sc_res = funct3[1] ? '0 : a;

        if (dec_ill)        imm_res = '0;
        else if (div_short) imm_res = sc_res;
        else                imm_res = base_op(funct3, op && f7_alt, f7_alt, a, b);
    end

    always_comb begin
        acc_d     = acc_q;
        opd_d     = opd_q;
        f3_d      = f3_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opd_q};
        case (state_q)
            S_IDLE: begin
                if (accept && (is_mul || (is_div && !div_short))) begin
                    f3_d   = funct3;
                    qneg_d = sa ^ sb;
                    rneg_d = sa;
                    if (is_mul) begin
                        acc_d = {{XLEN{1'b0}}, mag(b, sb)};
                        opd_d = mag(a, sa);
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mag(a, sa)};
                        opd_d = mag(b, sb);
                    end
                end
            end
            S_MUL: acc_d = {mul_sum, acc_q[XLEN-1:1]};
            S_DIV: begin
                // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1.
                if (!div_trial[XLEN]) acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                else                  acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
            S_FIX: acc_d = {mag(acc_q[2*XLEN-1:XLEN], rneg_q), mag(acc_q[XLEN-1:0], qneg_q)};
            default: ;
        endcase
    end

    always_comb begin
        prod = qneg_q ? -acc_q : acc_q;
        if (!f3_q[2]) seq_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else          seq_res = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            t_q         <= '0;
            illegal_q   <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q <= S_MUL;
                            cnt_q   <= CNT_TOP;
                        end else if (is_div && !div_short) begin
                            state_q <= S_DIV;
                            cnt_q   <= CNT_TOP;
                        end else begin
                            out_valid_q <= 1'b1;
                            t_q         <= imm_res;
                            illegal_q   <= dec_ill;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) state_q <= S_FIN;
                    else             cnt_q   <= cnt_q - CNT_ONE;
                end
                S_DIV: begin
                    if (cnt_q == '0) state_q <= S_FIX;
                    else             cnt_q   <= cnt_q - CNT_ONE;
                end
                S_FIX: state_q <= S_FIN;
                S_FIN: begin
                    if (!out_valid_q || out_ready) begin
                        out_valid_q <= 1'b1;
                        t_q         <= seq_res;
                        illegal_q   <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opd_q  <= opd_d;
        f3_q   <= f3_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at XLEN=32: vector table, scoreboard queue, and hand-written
// back-pressure, back-to-back and reset-abort sequences.
module tb_alu_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic        op_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] t;
    logic        illegal;

    alu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_imm(op_imm), .funct3(funct3), .funct7(funct7),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .t(t), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // edges: rising edges from the accept edge to the edge that raises out_valid
    typedef struct packed {
        logic        op;
        logic        op_imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        logic        ill;
        logic [7:0]  edges;
    } vec_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic        ill;
        logic [31:0] t;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic o, input logic oi, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a_, input logic [31:0] b_,
                                input logic [31:0] t_, input logic ill_, input logic [7:0] e_);
        vec_t v;
        v.op = o; v.op_imm = oi; v.f3 = f3; v.f7 = f7;
        v.a = a_; v.b = b_; v.t = t_; v.ill = ill_; v.edges = e_;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got t=%0h expected no result", t);
            end else begin
                mon_e = sb_q.pop_front();
                chk($sformatf("t_tag%0d", mon_e.tag), 64'(t), 64'(mon_e.t));
                chk($sformatf("illegal_tag%0d", mon_e.tag), 64'(illegal), 64'(mon_e.ill));
            end
        end
    end

    task automatic issue(input vec_t v, input logic [7:0] tag, output int acc_cyc);
        int   n;
        exp_t e;
        @(negedge clk);
        op = v.op; op_imm = v.op_imm; funct3 = v.f3; funct7 = v.f7; a = v.a; b = v.b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout tag=%0d in_ready=%b expected 1", tag, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            e.tag = tag; e.ill = v.ill; e.t = v.t;
            sb_q.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_result(input int acc_cyc, input logic [7:0] exp_edges, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_edges"}, 64'(cyc - acc_cyc), 64'(exp_edges));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   ac;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; op_imm = 1'b0;
        funct3 = '0; funct7 = '0; a = '0; b = '0; out_ready = 1'b1;

        vecs[0]  = mk(1, 0, 3'b000, 7'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0);
        vecs[1]  = mk(1, 0, 3'b000, 7'h20, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 0);
        vecs[2]  = mk(0, 1, 3'b101, 7'h20, 32'h80000000, 32'h00000021, 32'hC0000000, 0, 0);
        vecs[3]  = mk(1, 0, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0);
        vecs[4]  = mk(1, 0, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0);
        vecs[5]  = mk(0, 1, 3'b100, 7'h7F, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 0, 0);
        vecs[6]  = mk(1, 0, 3'b001, 7'h00, 32'h00000001, 32'h0000003F, 32'h80000000, 0, 0);
        vecs[7]  = mk(1, 0, 3'b101, 7'h00, 32'h80000000, 32'h00000004, 32'h08000000, 0, 0);
        vecs[8]  = mk(1, 0, 3'b111, 7'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0);
        vecs[9]  = mk(1, 1, 3'b000, 7'h00, 32'h00000003, 32'h00000004, 32'h00000000, 1, 0);
        vecs[10] = mk(0, 1, 3'b001, 7'h01, 32'h00000001, 32'h00000001, 32'h00000000, 1, 0);
        vecs[11] = mk(1, 0, 3'b000, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 33);
        vecs[12] = mk(1, 0, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33);
        vecs[13] = mk(1, 0, 3'b001, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 33);
        vecs[14] = mk(1, 0, 3'b010, 7'h01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0, 33);
        vecs[15] = mk(1, 0, 3'b000, 7'h01, 32'h00012345, 32'h00000100, 32'h01234500, 0, 33);
        vecs[16] = mk(1, 0, 3'b100, 7'h01, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 34);
        vecs[17] = mk(1, 0, 3'b110, 7'h01, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 34);
        vecs[18] = mk(1, 0, 3'b101, 7'h01, 32'd100,      32'd7,        32'd14,       0, 34);
        vecs[19] = mk(1, 0, 3'b111, 7'h01, 32'd100,      32'd7,        32'd2,        0, 34);
        vecs[20] = mk(1, 0, 3'b100, 7'h01, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 0, 0);
        vecs[21] = mk(1, 0, 3'b110, 7'h01, 32'd9,        32'h00000000, 32'd9,        0, 0);
        vecs[22] = mk(1, 0, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        vecs[23] = mk(1, 0, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_t", 64'(t), 64'(0));
        chk("rst_illegal", 64'(illegal), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], 8'(i), ac);
            wait_result(ac, vecs[i].edges, $sformatf("vec%0d", i));
        end

        // Multiply result held under back-pressure for five cycles.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(mk(1, 0, 3'b000, 7'h01, 32'd3, 32'd5, 32'd15, 0, 33), 8'd200, ac);
        wait_result(ac, 8'd33, "bp_mul");
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_t", 64'(t), 64'(15));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_drained", 64'(out_valid), 64'(0));

        // Back-to-back ADDs: a result on every cycle.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            op = 1'b1; op_imm = 1'b0; funct3 = 3'b000; funct7 = 7'h00;
            a = 32'(i * 16 + 1); b = 32'h100; in_valid = 1'b1;
            @(posedge clk);
            #1;
            e.tag = 8'(100 + i); e.ill = 1'b0; e.t = 32'(i * 16 + 1) + 32'h100;
            sb_q.push_back(e);
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", i), 64'(out_valid), 64'(1));
            chk($sformatf("b2b_in_ready%0d", i), 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;

        // Reset asserted ten cycles into a divide aborts it.
        issue(mk(1, 0, 3'b100, 7'h01, 32'd1000, 32'd3, 32'd333, 0, 34), 8'd210, ac);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", 64'(seen), 64'(0));
        issue(mk(1, 0, 3'b000, 7'h00, 32'd2, 32'd3, 32'd5, 0, 0), 8'd220, ac);
        wait_result(ac, 8'd0, "post_rst_add");
        issue(mk(1, 0, 3'b100, 7'h01, 32'd1000, 32'd3, 32'd333, 0, 34), 8'd221, ac);
        wait_result(ac, 8'd34, "post_rst_div");

        @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
